// File: rtl/reg_file.sv
// reg_file: two-read, one-write integer register file with x0 hardwired to zero
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset, clears every entry
//   we             write enable
//   waddr, wdata   write port (rd)
//   raddr1, rdata1 combinational read port 1 (rs1)
//   raddr2, rdata2 combinational read port 2 (rs2)
//
// Optional macro REGFILE_BYPASS_EN: forwards wdata to a read port that
// addresses the entry being written in the same cycle.
module reg_file #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [XLEN-1:0]   rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [XLEN-1:0]   rdata2
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding is gated by rst so a port under reset reads the cleared entry.
    logic fwd1, fwd2;
    always_comb begin
        fwd1   = rst && we && (waddr != '0) && (raddr1 == waddr);
        fwd2   = rst && we && (waddr != '0) && (raddr2 == waddr);
        rdata1 = (raddr1 == '0) ? '0 : fwd1 ? wdata : mem[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : fwd2 ? wdata : mem[raddr2];
    end
`else
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];
    end
`endif
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: vector table, corner sequences and randomized model check of reg_file
module tb_reg_file;
    logic        clk, rst, we;
    logic [4:0]  waddr, raddr1, raddr2;
    logic [31:0] wdata, rdata1, rdata2;
    int checks = 0;
    int errors = 0;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_file #(.XLEN(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r1, r2;
        logic [31:0] e1_pre, e2_pre, e1_post, e2_post;
    } vec_t;

    vec_t vt [6];
    logic [31:0] m [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference read: x0 is zero, otherwise stored value, with same-cycle
    // forwarding only in the bypass build.
    function automatic logic [31:0] ref_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (BYP && rst && we && waddr != 0 && waddr == a) return wdata;
        return m[a];
    endfunction

    initial begin
        vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5,
                  BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0,
                  32'hDEADBEEF, 32'hDEADBEEF};
        vt[1] = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5,
                  32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        vt[2] = '{1'b1, 5'd7, 32'h00000001, 5'd5, 5'd0,
                  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        vt[3] = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd7,
                  32'h0, BYP ? 32'hA5A5A5A5 : 32'h1, 32'h0, 32'hA5A5A5A5};
        vt[4] = '{1'b0, 5'd7, 32'h0, 5'd7, 5'd7,
                  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vt[5] = '{1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd7,
                  BYP ? 32'hCAFEF00D : 32'h0, 32'hA5A5A5A5, 32'hCAFEF00D, 32'hA5A5A5A5};

        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = 5'd1; raddr2 = 5'd31;
        #10;
        chk("reset_r1", rdata1, 32'h0);
        chk("reset_r2", rdata2, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            we = vt[i].we; waddr = vt[i].wa; wdata = vt[i].wd;
            raddr1 = vt[i].r1; raddr2 = vt[i].r2;
            #5;
            chk($sformatf("vec%0d_pre_r1", i), rdata1, vt[i].e1_pre);
            chk($sformatf("vec%0d_pre_r2", i), rdata2, vt[i].e2_pre);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_post_r1", i), rdata1, vt[i].e1_post);
            chk($sformatf("vec%0d_post_r2", i), rdata2, vt[i].e2_post);
        end

        // Mid-simulation reset clears everything before any clock edge.
        we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd7;
        #1;
        chk("pre_mid_reset_x5", rdata1, 32'hDEADBEEF);
        rst = 1'b0;
        #1;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a);
            #1;
            chk($sformatf("mid_reset_r1_x%0d", a), rdata1, 32'h0);
            chk($sformatf("mid_reset_r2_x%0d", 31 - a), rdata2, 32'h0);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset asserted during a write cycle and held across the edge loses the write.
        we = 1'b1; waddr = 5'd31; wdata = 32'hFFFFFFFF; raddr1 = 5'd31; raddr2 = 5'd31;
        #2 rst = 1'b0;
        #1;
        chk("rst_write_fwd_r1", rdata1, 32'h0);
        chk("rst_write_fwd_r2", rdata2, 32'h0);
        @(posedge clk); #1;
        we = 1'b0; rst = 1'b1;
        #1;
        chk("rst_write_lost_x31", rdata1, 32'h0);

        // Fill x1..x31 and sweep both ports.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = i * 32'h01010101;
            @(posedge clk); #1;
        end
        we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a);
            #1;
            chk($sformatf("sweep_r1_x%0d", a), rdata1, a * 32'h01010101);
            chk($sformatf("sweep_r2_x%0d", 31 - a), rdata2, (31 - a) * 32'h01010101);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 32; i++) m[i] = i * 32'h01010101;
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1)); waddr = 5'($urandom); wdata = $urandom;
            raddr1 = 5'($urandom); raddr2 = (n % 4 == 0) ? waddr : 5'($urandom);
            #5;
            chk("rand_r1", rdata1, ref_rd(raddr1));
            chk("rand_r2", rdata2, ref_rd(raddr2));
            @(posedge clk); #1;
            if (we && waddr != 0) m[waddr] = wdata;
        end
        we = 1'b0;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a);
            #1;
            chk("final_r1", rdata1, (a == 0) ? 32'h0 : m[a]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
